// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client Sysbus memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    localparam int       BURST_BEATS   = 8;
    localparam int       WRITE_TAG_BIT = 12;
    localparam logic     SYSBUS_WRITE  = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: rr_ptr names the preferred client when both request.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    assign grant = (&req) ? rr_ptr : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges the I-cache (c0) and D-cache (c1) memory ports onto one Sysbus DRAM port.
// Optional grant counters are built when MEM_ARB_PERF_EN is defined.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      c0_bus_reqcyc,
    output logic                      c0_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c0_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c0_bus_reqtag,
    output logic                      c0_bus_respcyc,
    input  logic                      c0_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] c0_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c0_bus_resptag,

    input  logic                      c1_bus_reqcyc,
    output logic                      c1_bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] c1_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  c1_bus_reqtag,
    output logic                      c1_bus_respcyc,
    input  logic                      c1_bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] c1_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  c1_bus_resptag,

    output logic                      m_bus_reqcyc,
    input  logic                      m_bus_reqack,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_respcyc,
    output logic                      m_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]               perf_grants0,
    output logic [31:0]               perf_grants1
`endif
);

    localparam logic [2:0] LAST_BEAT = 3'(BURST_BEATS - 1);

    arb_state_t state;
    logic       owner;
    logic       rr_ptr;
    logic [2:0] beat;

    logic       pick_grant;
    logic       pick_valid;

    rr_pick2 u_pick (
        .req    ({c1_bus_reqcyc, c0_bus_reqcyc}),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .valid  (pick_valid)
    );

    logic                      own_reqcyc;
    logic                      own_respack;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;

    assign own_reqcyc  = owner ? c1_bus_reqcyc  : c0_bus_reqcyc;
    assign own_respack = owner ? c1_bus_respack : c0_bus_respack;
    assign own_req     = owner ? c1_bus_req     : c0_bus_req;
    assign own_reqtag  = owner ? c1_bus_reqtag  : c0_bus_reqtag;

    logic req_phase;
    logic resp_phase;
    logic req_hs;
    logic resp_hs;
    logic last_beat;

    assign req_phase  = (state == ADDR) || (state == WDATA);
    assign resp_phase = (state == RDATA);

    // Request side: only the owner is ever visible to DRAM, and only outside IDLE.
    assign m_bus_reqcyc = req_phase & own_reqcyc;
    assign m_bus_req    = req_phase ? own_req    : '0;
    assign m_bus_reqtag = req_phase ? own_reqtag : '0;
    assign req_hs       = m_bus_reqcyc & m_bus_reqack;

    assign c0_bus_reqack = req_hs & ~owner;
    assign c1_bus_reqack = req_hs &  owner;

    // Response side: DRAM responses outside RDATA are dropped and never acked.
    assign c0_bus_respcyc = resp_phase & ~owner & m_bus_respcyc;
    assign c1_bus_respcyc = resp_phase &  owner & m_bus_respcyc;
    assign c0_bus_resp    = (resp_phase & ~owner) ? m_bus_resp    : '0;
    assign c1_bus_resp    = (resp_phase &  owner) ? m_bus_resp    : '0;
    assign c0_bus_resptag = (resp_phase & ~owner) ? m_bus_resptag : '0;
    assign c1_bus_resptag = (resp_phase &  owner) ? m_bus_resptag : '0;
    assign m_bus_respack  = resp_phase & own_respack;
    assign resp_hs        = m_bus_respcyc & m_bus_respack;

    assign last_beat = (beat == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            beat   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_grant;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (req_hs) begin
                        state <= (own_reqtag[WRITE_TAG_BIT] == SYSBUS_WRITE) ? WDATA : RDATA;
                        beat  <= '0;
                    end
                end
                WDATA: begin
                    if (req_hs) begin
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= ~owner;
                            beat   <= '0;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                RDATA: begin
                    if (resp_hs) begin
                        if (last_beat) begin
                            state  <= IDLE;
                            rr_ptr <= ~owner;
                            beat   <= '0;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic grant_evt;
    assign grant_evt = (state == ADDR) & req_hs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grants0 <= '0;
            perf_grants1 <= '0;
        end else if (grant_evt) begin
            if (!owner && perf_grants0 != 32'hFFFF_FFFF) perf_grants0 <= perf_grants0 + 32'd1;
            if ( owner && perf_grants1 != 32'hFFFF_FFFF) perf_grants1 <= perf_grants1 + 32'd1;
        end
    end
`endif

endmodule
